// File: rtl/led_sequencer_if.sv
// led_sequencer_if: board switch inputs and LED bank outputs of led_sequencer.
interface led_sequencer_if #(parameter int NB_LEDS = 4);
    logic               i_enable;
    logic [1:0]         i_speed;
    logic [1:0]         i_mode;
    logic [1:0]         i_color;
    logic [NB_LEDS-1:0] o_led;
    logic [NB_LEDS-1:0] o_led_b;
    logic [NB_LEDS-1:0] o_led_g;
    logic [NB_LEDS-1:0] o_led_r;
    logic               o_step;
    modport master (
        output i_enable, i_speed, i_mode, i_color,
        input  o_led, o_led_b, o_led_g, o_led_r, o_step
    );
    modport slave (
        input  i_enable, i_speed, i_mode, i_color,
        output o_led, o_led_b, o_led_g, o_led_r, o_step
    );
endinterface

// File: rtl/led_sequencer.sv
// led_sequencer: prescaled multi-mode LED pattern generator with colour plane routing.
// Define LED_SEQ_PINGPONG_EN to make mode 10 ping-pong; otherwise mode 10 rotates left.
module led_sequencer #(
    parameter int NB_LEDS    = 4,
    parameter int NB_COUNTER = 16
) (
    input  logic            clock,
    input  logic            i_reset,
    led_sequencer_if.slave  bus
);
    localparam logic [NB_LEDS-1:0] ONE = NB_LEDS'(1);

    logic [NB_COUNTER-1:0] counter;
    logic [NB_COUNTER-1:0] limit;
    logic [NB_LEDS-1:0]    pattern;
    logic [NB_LEDS-1:0]    next_pattern;
    logic [NB_LEDS-1:0]    rol;
    logic [NB_LEDS-1:0]    ror;
    logic [NB_LEDS-1:0]    fill;
    logic [NB_LEDS-1:0]    pp;
    logic [1:0]            mode_q;
    logic                  step_q;
    logic                  strobe;
    logic                  restart;

    // 2^(NB_COUNTER-10-speed)-1 is simply all-ones shifted down
    assign limit   = {NB_COUNTER{1'b1}} >> (10 + bus.i_speed);
    assign strobe  = bus.i_enable && counter >= limit;
    assign restart = i_reset || bus.i_mode != mode_q;

    assign rol  = {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
    assign ror  = {pattern[0], pattern[NB_LEDS-1:1]};
    assign fill = &pattern ? ONE : {pattern[NB_LEDS-2:0], 1'b1};

`ifdef LED_SEQ_PINGPONG_EN
    logic dir;
    assign pp = dir ? pattern >> 1 : pattern << 1;
`else
    assign pp = rol;
`endif

    always_comb begin
        next_pattern = mode_q == 2'b00 ? rol :
                       mode_q == 2'b01 ? ror :
                       mode_q == 2'b10 ? pp  : fill;
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            counter <= '0;
            pattern <= ONE;
            mode_q  <= bus.i_mode;
            step_q  <= 1'b0;
`ifdef LED_SEQ_PINGPONG_EN
            dir     <= 1'b0;
`endif
        end else begin
            step_q <= strobe;
            if (bus.i_enable)
                counter <= strobe ? '0 : counter + 1'b1;
            if (strobe)
                pattern <= next_pattern;
`ifdef LED_SEQ_PINGPONG_EN
            // bounce when the lit LED reaches either end
            if (strobe && mode_q == 2'b10)
                dir <= dir ? !pp[0] : pp[NB_LEDS-1];
`endif
        end
    end

    assign bus.o_led   = pattern;
    assign bus.o_step  = step_q;
    assign bus.o_led_b = (bus.i_color == 2'b00 || bus.i_color == 2'b11) ? pattern : '0;
    assign bus.o_led_g = (bus.i_color == 2'b01 || bus.i_color == 2'b11) ? pattern : '0;
    assign bus.o_led_r = (bus.i_color == 2'b10 || bus.i_color == 2'b11) ? pattern : '0;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: table vectors, directed corner sequences and a randomized run against a step-index model.
module tb_led_sequencer;
    logic clock   = 1'b0;
    logic i_reset = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   m_cnt   = 0;
    int   m_k     = 0;
    int   m_mode  = 0;
    logic m_step  = 1'b0;

    led_sequencer_if #(.NB_LEDS(4)) bus ();

    led_sequencer #(.NB_LEDS(4), .NB_COUNTER(16)) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] speed;
        logic [1:0] mode;
        logic [1:0] color;
        int         n;
        logic [3:0] led;
        logic       step;
    } vec_t;

    vec_t vecs [14];

    // pattern after k steps since the last reset or mode change
    function automatic logic [3:0] ref_led(int mode, int k);
        case (mode)
            0: return 4'(1 << (k % 4));
            1: return 4'(1 << ((4 - k % 4) % 4));
`ifdef LED_SEQ_PINGPONG_EN
            2: begin
                int p = k % 6;
                return 4'(1 << (p < 4 ? p : 6 - p));
            end
`else
            2: return 4'(1 << (k % 4));
`endif
            default: return 4'((1 << (k % 4 + 1)) - 1);
        endcase
    endfunction

    function automatic logic [3:0] plane(logic [1:0] color, int idx, logic [3:0] led);
        return (color == 2'b11 || int'(color) == idx) ? led : 4'b0000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set(logic rst, logic en, logic [1:0] speed, logic [1:0] mode, logic [1:0] color);
        i_reset      = rst;
        bus.i_enable = en;
        bus.i_speed  = speed;
        bus.i_mode   = mode;
        bus.i_color  = color;
    endtask

    task automatic tick();
        @(posedge clock);
        if (i_reset || int'(bus.i_mode) != m_mode) begin
            m_mode = int'(bus.i_mode);
            m_cnt  = 0;
            m_k    = 0;
            m_step = 1'b0;
        end else begin
            m_step = 1'b0;
            if (bus.i_enable) begin
                if (m_cnt >= (1 << (6 - int'(bus.i_speed))) - 1) begin
                    m_cnt  = 0;
                    m_k++;
                    m_step = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic check_all(string tag, logic [3:0] led, logic step);
        chk({tag, "_led"},  bus.o_led,   led);
        chk({tag, "_step"}, bus.o_step,  step);
        chk({tag, "_b"},    bus.o_led_b, plane(bus.i_color, 0, led));
        chk({tag, "_g"},    bus.o_led_g, plane(bus.i_color, 1, led));
        chk({tag, "_r"},    bus.o_led_r, plane(bus.i_color, 2, led));
    endtask

    task automatic wait_step(output logic [3:0] led, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_step && n < 300);
        led = bus.o_led;
    endtask

    initial begin
        logic [3:0] led;
        int         n;
`ifdef LED_SEQ_PINGPONG_EN
        logic [3:0] pp_exp [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
`else
        logic [3:0] pp_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        logic [3:0] fill_exp [6] = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011, 4'b0111};

        vecs[0]  = '{1'b1, 1'b1, 2'd3, 2'd0, 2'd0,   2, 4'b0001, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd0,   7, 4'b0001, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd0,   1, 4'b0010, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd0,   1, 4'b0010, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd1,   6, 4'b0010, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd2,   1, 4'b0100, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd2,   3, 4'b0100, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 2'd0, 2'd2, 100, 4'b0100, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd3,   4, 4'b0100, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd3,   1, 4'b1000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd3,   4, 4'b1000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd3, 2'd0, 2'd0,   1, 4'b0001, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd0,   7, 4'b0001, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd0,   1, 4'b0010, 1'b1};

        set(1'b1, 1'b1, 2'd3, 2'd0, 2'd0);
        @(negedge clock);
        for (int v = 0; v < 14; v++) begin
            set(vecs[v].rst, vecs[v].en, vecs[v].speed, vecs[v].mode, vecs[v].color);
            for (int c = 0; c < vecs[v].n; c++) begin
                tick();
                check_all($sformatf("vec%0d", v), vecs[v].led, vecs[v].step);
            end
        end

        // slowest rate, then back to the fastest
        set(1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
        tick();
        set(1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
        wait_step(led, n);
        chk("rate64_cycles", n, 64);
        chk("rate64_led", led, 4'b0010);
        wait_step(led, n);
        chk("rate64_cycles2", n, 64);
        chk("rate64_led2", led, 4'b0100);
        bus.i_speed = 2'd3;
        for (int s = 0; s < 4; s++) begin
            wait_step(led, n);
            chk("rate8_cycles", n, 8);
            chk("rate8_led", led, ref_led(0, 3 + s));
        end

        // shrinking the limit below the current count strobes immediately
        set(1'b1, 1'b1, 2'd0, 2'd0, 2'd0);
        tick();
        set(1'b0, 1'b1, 2'd0, 2'd0, 2'd0);
        for (int c = 0; c < 20; c++) tick();
        check_all("slow_mid", 4'b0001, 1'b0);
        bus.i_speed = 2'd3;
        tick();
        check_all("speed_drop", 4'b0010, 1'b1);

        // mode 10
        bus.i_mode = 2'd2;
        tick();
        check_all("pp_start", 4'b0001, 1'b0);
        foreach (pp_exp[i]) begin
            wait_step(led, n);
            chk("pp_cycles", n, 8);
            chk($sformatf("pp_led%0d", i), led, pp_exp[i]);
        end

        // fill, then switch to rotate right from 0111
        bus.i_mode = 2'd3;
        tick();
        check_all("fill_start", 4'b0001, 1'b0);
        foreach (fill_exp[i]) begin
            wait_step(led, n);
            chk("fill_cycles", n, 8);
            chk($sformatf("fill_led%0d", i), led, fill_exp[i]);
        end
        bus.i_mode = 2'd1;
        tick();
        check_all("modechg", 4'b0001, 1'b0);
        for (int c = 0; c < 7; c++) begin
            tick();
            check_all("modechg_hold", 4'b0001, 1'b0);
        end
        tick();
        check_all("modechg_step", 4'b1000, 1'b1);

        // colour routing on pattern 0100
        wait_step(led, n);
        chk("color_pattern", led, 4'b0100);
        for (int c = 0; c < 4; c++) begin
            bus.i_color = 2'(c);
            #1;
            chk($sformatf("color%0d_b", c), bus.o_led_b, (c == 0 || c == 3) ? 4'b0100 : 4'b0000);
            chk($sformatf("color%0d_g", c), bus.o_led_g, (c == 1 || c == 3) ? 4'b0100 : 4'b0000);
            chk($sformatf("color%0d_r", c), bus.o_led_r, (c == 2 || c == 3) ? 4'b0100 : 4'b0000);
        end
        wait_step(led, n);
        chk("color_cadence", n, 8);
        chk("color_next", led, 4'b0010);

        // randomized run against the step-index model
        set(1'b1, 1'b1, 2'd3, 2'd0, 2'd0);
        tick();
        for (int i = 0; i < 4000; i++) begin
            i_reset      = ($urandom % 300) == 0;
            bus.i_enable = ($urandom % 5) != 0;
            if ($urandom % 100 == 0) bus.i_speed = 2'($urandom);
            if ($urandom % 150 == 0) bus.i_mode = 2'($urandom);
            bus.i_color = 2'($urandom);
            tick();
            check_all("rand", ref_led(m_mode, m_k), m_step);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
